// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game controller for an N x N board.
// O is the user (moves via move_valid/move_idx); X is an external
// combinational engine whose one-hot suggestion is captured in X_TURN.
// Square i of a board is bit i; bit N*N-1 is the top-left square (row-major,
// MSB first).
// Optional feature: define TTT_SCORE_EN to build the x/o/draw score
// counters; without it the score outputs are constant 0.
module ttt_game_ctrl #(
  parameter int N       = 3,
  parameter int SCORE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     o_first,
  input  logic                     move_valid,
  input  logic [$clog2(N*N)-1:0]   move_idx,
  output logic                     move_ready,
  input  logic [N*N-1:0]           eng_move,
  output logic [N*N-1:0]           xboard,
  output logic [N*N-1:0]           oboard,
  output logic                     illegal,
  output logic                     eng_fault,
  output logic                     game_over,
  output logic [1:0]               winner,
  output logic [SCORE_W-1:0]       x_score,
  output logic [SCORE_W-1:0]       o_score,
  output logic [SCORE_W-1:0]       draws
);

  localparam int SQ = N * N;
  localparam logic [SQ-1:0] ONE = SQ'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] O_TURN = 3'd1;
  localparam logic [2:0] X_TURN = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_X    = 2'b01;
  localparam logic [1:0] W_O    = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  logic [2:0]    state_reg, state_next;
  logic [SQ-1:0] xboard_reg, xboard_next;
  logic [SQ-1:0] oboard_reg, oboard_next;
  logic [1:0]    winner_reg, winner_next;
  logic          illegal_reg, illegal_next;
  logic          eng_fault_reg, eng_fault_next;
  logic          last_x_reg, last_x_next;

  logic [SQ-1:0] occ, empty, empty_neg, low_empty;
  logic [SQ-1:0] move_onehot, eng_dec, x_pick;
  logic          move_legal, eng_ok;
  logic [SQ-1:0] chk_board;
  logic [N-1:0]  row_win, col_win, diag_bits, anti_bits;
  logic          line_win;

  // Square bookkeeping: occupancy, lowest empty square, move legality.
  always_comb begin
    occ         = xboard_reg | oboard_reg;
    empty       = ~occ;
    empty_neg   = ~empty + ONE;
    low_empty   = empty & empty_neg;
    // An out-of-range index shifts the bit out entirely, giving zero.
    move_onehot = ONE << move_idx;
    move_legal  = (move_onehot != '0) && ((move_onehot & occ) == '0);
    eng_dec     = eng_move - ONE;
    eng_ok      = (eng_move != '0) && ((eng_move & eng_dec) == '0) &&
                  ((eng_move & occ) == '0);
    x_pick      = eng_ok ? eng_move : low_empty;
  end

  // Line detection on the board of the player who just moved.
  assign chk_board = last_x_reg ? xboard_reg : oboard_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    logic [N-1:0] row_bits;
    logic [N-1:0] col_bits;
    for (genvar gj = 0; gj < N; gj++) begin : g_cell
      assign row_bits[gj] = chk_board[gi*N + gj];
      assign col_bits[gj] = chk_board[gj*N + gi];
    end
    assign row_win[gi]   = &row_bits;
    assign col_win[gi]   = &col_bits;
    // Main diagonal runs top-left to bottom-right; anti-diagonal the other way.
    assign diag_bits[gi] = chk_board[gi*(N+1)];
    assign anti_bits[gi] = chk_board[(gi+1)*(N-1)];
  end

  assign line_win = (|row_win) | (|col_win) | (&diag_bits) | (&anti_bits);

  // Next-state and next-board computation for the game FSM.
  always_comb begin
    state_next     = state_reg;
    xboard_next    = xboard_reg;
    oboard_next    = oboard_reg;
    winner_next    = winner_reg;
    last_x_next    = last_x_reg;
    illegal_next   = 1'b0;
    eng_fault_next = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          xboard_next = '0;
          oboard_next = '0;
          winner_next = W_NONE;
          state_next  = o_first ? O_TURN : X_TURN;
        end
      end
      O_TURN: begin
        if (move_valid) begin
          if (move_legal) begin
            oboard_next = oboard_reg | move_onehot;
            last_x_next = 1'b0;
            state_next  = CHECK;
          end else begin
            illegal_next = 1'b1;
          end
        end
      end
      X_TURN: begin
        xboard_next    = xboard_reg | x_pick;
        eng_fault_next = ~eng_ok;
        last_x_next    = 1'b1;
        state_next     = CHECK;
      end
      CHECK: begin
        // A completed line wins even when it also fills the board.
        if (line_win) begin
          winner_next = last_x_reg ? W_X : W_O;
          state_next  = DONE;
        end else if (&occ) begin
          winner_next = W_DRAW;
          state_next  = DONE;
        end else begin
          state_next  = last_x_reg ? O_TURN : X_TURN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      xboard_reg    <= '0;
      oboard_reg    <= '0;
      winner_reg    <= W_NONE;
      illegal_reg   <= 1'b0;
      eng_fault_reg <= 1'b0;
      last_x_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      xboard_reg    <= xboard_next;
      oboard_reg    <= oboard_next;
      winner_reg    <= winner_next;
      illegal_reg   <= illegal_next;
      eng_fault_reg <= eng_fault_next;
      last_x_reg    <= last_x_next;
    end
  end

  assign xboard     = xboard_reg;
  assign oboard     = oboard_reg;
  assign winner     = winner_reg;
  assign illegal    = illegal_reg;
  assign eng_fault  = eng_fault_reg;
  assign move_ready = (state_reg == O_TURN);
  assign game_over  = (state_reg == DONE);

`ifdef TTT_SCORE_EN
  logic [SCORE_W-1:0] x_score_reg, o_score_reg, draws_reg;

  // Score one result on the CHECK->DONE transition; counters wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_score_reg <= '0;
      o_score_reg <= '0;
      draws_reg   <= '0;
    end else if (state_reg == CHECK && state_next == DONE) begin
      case (winner_next)
        W_X:     x_score_reg <= x_score_reg + SCORE_W'(1);
        W_O:     o_score_reg <= o_score_reg + SCORE_W'(1);
        W_DRAW:  draws_reg   <= draws_reg + SCORE_W'(1);
        default: ;
      endcase
    end
  end

  assign x_score = x_score_reg;
  assign o_score = o_score_reg;
  assign draws   = draws_reg;
`else
  assign x_score = '0;
  assign o_score = '0;
  assign draws   = '0;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl: directed bench for ttt_game_ctrl with a 3x3 instance
// and a 4x4 instance (2-bit scores). sel4 routes start/move_valid to one of them.
module tb_ttt_game_ctrl;

`ifdef TTT_SCORE_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, o_first, move_valid, sel4;
  logic [3:0]  mi;
  logic [15:0] em;

  logic       move_ready3, illegal3, eng_fault3, game_over3;
  logic [8:0] xboard3, oboard3;
  logic [1:0] winner3;
  logic [7:0] x_score3, o_score3, draws3;

  logic        move_ready4, illegal4, eng_fault4, game_over4;
  logic [15:0] xboard4, oboard4;
  logic [1:0]  winner4;
  logic [1:0]  x_score4, o_score4, draws4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl #(.N(3), .SCORE_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start & ~sel4), .o_first(o_first),
    .move_valid(move_valid & ~sel4), .move_idx(mi), .move_ready(move_ready3),
    .eng_move(em[8:0]), .xboard(xboard3), .oboard(oboard3), .illegal(illegal3),
    .eng_fault(eng_fault3), .game_over(game_over3), .winner(winner3),
    .x_score(x_score3), .o_score(o_score3), .draws(draws3)
  );

  ttt_game_ctrl #(.N(4), .SCORE_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start & sel4), .o_first(o_first),
    .move_valid(move_valid & sel4), .move_idx(mi), .move_ready(move_ready4),
    .eng_move(em), .xboard(xboard4), .oboard(oboard4), .illegal(illegal4),
    .eng_fault(eng_fault4), .game_over(game_over4), .winner(winner4),
    .x_score(x_score4), .o_score(o_score4), .draws(draws4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_game(input logic of);
    o_first = of;
    start = 1'b1;
    step();
    start = 1'b0;
    $display("start game o_first=%0d sel4=%0d", of, sel4);
  endtask

  // O move through O_TURN and CHECK.
  task automatic o_play(input int idx);
    mi = 4'(idx);
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    step();
    $display("O move idx=%0d", idx);
  endtask

  // X move through X_TURN and CHECK, checking the fault pulse.
  task automatic x_play(input logic [15:0] e, input logic exp_fault, input string tag);
    em = e;
    step();
    check(tag, 32'(sel4 ? eng_fault4 : eng_fault3), 32'(exp_fault));
    step();
    check({tag, "_clr"}, 32'(sel4 ? eng_fault4 : eng_fault3), 32'(0));
    $display("X engine move=%0h", e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; o_first = 1'b0; move_valid = 1'b0;
    sel4 = 1'b0; mi = '0; em = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_xboard", 32'(xboard3), 32'(0));
    check("rst_oboard", 32'(oboard3), 32'(0));
    check("rst_winner", 32'(winner3), 32'(0));
    check("rst_ready", 32'(move_ready3), 32'(0));
    check("rst_over", 32'(game_over3), 32'(0));
    check("rst_illegal", 32'(illegal3), 32'(0));
    check("rst_fault", 32'(eng_fault3), 32'(0));
    check("rst_oscore", 32'(o_score3), 32'(0));
    check("rst_x4score", 32'(x_score4), 32'(0));

    // move_valid in IDLE is ignored
    mi = 4'd0; move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    check("idle_illegal", 32'(illegal3), 32'(0));
    check("idle_oboard", 32'(oboard3), 32'(0));

    // Game 1: O wins on the top row
    new_game(1'b1);
    check("g1_ready", 32'(move_ready3), 32'(1));
    o_play(8);
    check("g1_oboard1", 32'(oboard3), 32'h100);
    check("g1_xturn_ready", 32'(move_ready3), 32'(0));
    x_play(16'h0010, 1'b0, "g1_x1");
    o_play(7);
    x_play(16'h0001, 1'b0, "g1_x2");
    o_play(6);
    check("g1_over", 32'(game_over3), 32'(1));
    check("g1_winner", 32'(winner3), 32'(2));
    check("g1_oboard", 32'(oboard3), 32'h1C0);
    check("g1_xboard", 32'(xboard3), 32'h011);
    check("g1_oscore", 32'(o_score3), 32'(SC));
    check("g1_xscore", 32'(x_score3), 32'(0));
    check("g1_ready_done", 32'(move_ready3), 32'(0));
    mi = 4'd5; move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    check("done_illegal", 32'(illegal3), 32'(0));
    check("done_oboard", 32'(oboard3), 32'h1C0);
    step();
    check("g1_oscore_once", 32'(o_score3), 32'(SC));

    // Game 2: X first; illegal moves, engine faults, then a draw
    new_game(1'b0);
    check("g2_clr_x", 32'(xboard3), 32'(0));
    check("g2_clr_o", 32'(oboard3), 32'(0));
    check("g2_clr_win", 32'(winner3), 32'(0));
    check("g2_clr_over", 32'(game_over3), 32'(0));
    x_play(16'h0010, 1'b0, "g2_x1");
    mi = 4'd4; move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    check("occ_illegal", 32'(illegal3), 32'(1));
    check("occ_oboard", 32'(oboard3), 32'(0));
    check("occ_xboard", 32'(xboard3), 32'h010);
    check("occ_ready", 32'(move_ready3), 32'(1));
    step();
    check("occ_pulse_end", 32'(illegal3), 32'(0));
    check("occ_ready2", 32'(move_ready3), 32'(1));
    mi = 4'd9; move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    check("range_illegal", 32'(illegal3), 32'(1));
    check("range_oboard", 32'(oboard3), 32'(0));
    o_first = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored", 32'(move_ready3), 32'(1));
    check("start_ign_x", 32'(xboard3), 32'h010);
    o_play(0);
    x_play(16'h0003, 1'b1, "g2_multi_hot");
    check("g2_low_empty1", 32'(xboard3), 32'h012);
    o_play(2);
    x_play(16'h0010, 1'b1, "g2_occupied");
    check("g2_low_empty2", 32'(xboard3), 32'h01A);
    o_play(7);
    x_play(16'h0100, 1'b0, "g2_x4");
    check("g2_not_over", 32'(game_over3), 32'(0));
    o_play(5);
    x_play(16'h0040, 1'b0, "g2_x5");
    check("draw_over", 32'(game_over3), 32'(1));
    check("draw_winner", 32'(winner3), 32'(3));
    check("draw_xboard", 32'(xboard3), 32'h15A);
    check("draw_oboard", 32'(oboard3), 32'h0A5);
    check("draw_count", 32'(draws3), 32'(SC));
    check("draw_oscore", 32'(o_score3), 32'(SC));

    // Game 3: O completes a diagonal on the last square
    new_game(1'b1);
    o_play(8);
    x_play(16'h0080, 1'b0, "g3_x1");
    o_play(6);
    x_play(16'h0020, 1'b0, "g3_x2");
    o_play(4);
    x_play(16'h0008, 1'b0, "g3_x3");
    o_play(1);
    x_play(16'h0004, 1'b0, "g3_x4");
    o_play(0);
    check("last_win_winner", 32'(winner3), 32'(2));
    check("last_win_oboard", 32'(oboard3), 32'h153);
    check("last_win_oscore", 32'(o_score3), 32'(2 * SC));
    check("last_win_draws", 32'(draws3), 32'(SC));

    // Reset during X_TURN clears everything before the next edge
    new_game(1'b1);
    o_play(8);
    check("pre_rst_oboard", 32'(oboard3), 32'h100);
    check("pre_rst_xturn", 32'(move_ready3), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("arst_oboard", 32'(oboard3), 32'(0));
    check("arst_xboard", 32'(xboard3), 32'(0));
    check("arst_winner", 32'(winner3), 32'(0));
    check("arst_over", 32'(game_over3), 32'(0));
    check("arst_ready", 32'(move_ready3), 32'(0));
    check("arst_fault", 32'(eng_fault3), 32'(0));
    check("arst_oscore", 32'(o_score3), 32'(0));
    check("arst_draws", 32'(draws3), 32'(0));
    #3 rst = 1'b0;
    step();
    step();
    check("post_rst_ready", 32'(move_ready3), 32'(0));
    check("post_rst_over", 32'(game_over3), 32'(0));
    check("post_rst_xscore", 32'(x_score3), 32'(0));

    // 4x4: X wins via the anti-diagonal five times, 2-bit score wraps
    sel4 = 1'b1;
    for (int g = 1; g <= 5; g++) begin
      new_game(1'b0);
      x_play(16'h0008, 1'b0, "n4_x1");
      o_play(15);
      x_play(16'h0040, 1'b0, "n4_x2");
      o_play(14);
      x_play(16'h0200, 1'b0, "n4_x3");
      o_play(13);
      x_play(16'h1000, 1'b0, "n4_x4");
      check("n4_over", 32'(game_over4), 32'(1));
      check("n4_winner", 32'(winner4), 32'(1));
      check("n4_xboard", 32'(xboard4), 32'h1248);
      check("n4_oboard", 32'(oboard4), 32'hE000);
      check("n4_xscore", 32'(x_score4), 32'((g * SC) % 4));
    end
    check("n4_oscore", 32'(o_score4), 32'(0));
    check("n3_idle_ready", 32'(move_ready3), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
